// File: rtl/instr_encoder.sv
// Purpose : packs decoded RV32I field bundles into instruction words and writes them to imem, then an all-zero terminator.
// Latency : a legal bundle is written one cycle after transfer; at most one instruction every 2 cycles.
// Backpressure: in_ready drops during WRITE/TERM/DONE, while finish is asserted, and once only the terminator slot is left.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_valid / in_ready            field-bundle handshake
//   cls, rd, rs1, rs2, func3, alt, imm   decoded instruction fields
//   finish                         write the terminator and stop
//   start                          leave DONE and restart at BASE_ADDR
//   mem_we, mem_addr, mem_wdata    instruction-memory write port
//   err, err_code                  reject pulse and sticky reason (1 func3/alt, 2 imm range, 3 full)
//   count, done                    instructions written, terminator written
module instr_encoder #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        cls,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        func3,
    input  logic              alt,
    input  logic [31:0]       imm,
    input  logic              finish,
    input  logic              start,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   count,
    output logic              done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_TERM  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [2:0] C_LW   = 3'd0;
    localparam logic [2:0] C_SW   = 3'd1;
    localparam logic [2:0] C_R    = 3'd2;
    localparam logic [2:0] C_B    = 3'd3;
    localparam logic [2:0] C_I    = 3'd4;
    localparam logic [2:0] C_JALR = 3'd5;
    localparam logic [2:0] C_JAL  = 3'd6;
    localparam logic [2:0] C_LUI  = 3'd7;

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    // Highest instruction count; the slot after it belongs to the terminator.
    localparam logic [ADDR_W:0]   CNT_LAST = (ADDR_W+1)'(DEPTH - 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   count_q;
    logic [31:0]       word_q;
    logic              err_q;
    logic [1:0]        err_code_q;

    logic [31:0] enc_word;
    logic        f3_bad;
    logic        imm_bad;

    // Signed-range checks: upper bits must all equal the sign bit.
    logic fits12, fits13, fits21;
    assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);

    always_comb begin
        enc_word = 32'h0;
        f3_bad   = 1'b0;
        imm_bad  = 1'b0;
        case (cls)
            C_LW: begin
                imm_bad  = ~fits12;
                enc_word = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
            end
            C_SW: begin
                imm_bad  = ~fits12;
                enc_word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            end
            C_R: begin
                f3_bad   = ~(func3 == 3'b000 || func3 == 3'b010 || func3 == 3'b100 ||
                             func3 == 3'b110 || func3 == 3'b111);
                enc_word = {1'b0, alt, 5'b00000, rs2, rs1, func3, rd, 7'b0110011};
            end
            C_B: begin
                f3_bad   = ~(func3 == 3'b000 || func3 == 3'b001 ||
                             func3 == 3'b100 || func3 == 3'b101);
                imm_bad  = ~fits13 | imm[0];
                enc_word = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], 7'b1100011};
            end
            C_I: begin
                f3_bad   = ~(func3 == 3'b000 || func3 == 3'b010 || func3 == 3'b100 ||
                             func3 == 3'b110 || func3 == 3'b111);
                imm_bad  = ~fits12;
                enc_word = {imm[11:0], rs1, func3, rd, 7'b0010011};
            end
            C_JALR: begin
                imm_bad  = ~fits12;
                enc_word = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
            end
            C_JAL: begin
                imm_bad  = ~fits21 | imm[0];
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
            end
            C_LUI: begin
                imm_bad  = |imm[11:0];
                enc_word = {imm[31:12], rd, 7'b0110111};
            end
            default: begin
                enc_word = 32'h0;
            end
        endcase
        // sub is the only func7 variant encoded; anywhere else alt is a field error.
        if (alt && !(cls == C_R && func3 == 3'b000)) begin
            f3_bad = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            addr_q     <= BASE;
            count_q    <= '0;
            word_q     <= 32'h0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
        end else begin
            err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (finish) begin
                        // finish outranks a simultaneous bundle
                        word_q <= 32'h0;
                        state  <= S_TERM;
                    end else if (in_valid) begin
                        if (count_q == CNT_LAST) begin
                            err_q      <= 1'b1;
                            err_code_q <= 2'd3;
                        end else if (f3_bad) begin
                            err_q      <= 1'b1;
                            err_code_q <= 2'd1;
                        end else if (imm_bad) begin
                            err_q      <= 1'b1;
                            err_code_q <= 2'd2;
                        end else begin
                            word_q <= enc_word;
                            state  <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    addr_q  <= addr_q + 1'b1;
                    count_q <= count_q + 1'b1;
                    state   <= S_IDLE;
                end
                S_TERM: begin
                    state <= S_DONE;
                end
                S_DONE: begin
                    if (start) begin
                        addr_q  <= BASE;
                        count_q <= '0;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Write strobe decoded from state so an asynchronous reset kills it immediately.
    assign mem_we    = (state == S_WRITE) || (state == S_TERM);
    assign mem_addr  = addr_q;
    assign mem_wdata = word_q;
    assign in_ready  = (state == S_IDLE) && (count_q < CNT_LAST) && !finish;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign count     = count_q;
    assign done      = (state == S_DONE);

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
    localparam int ADDR_W    = 10;
    localparam int BASE_ADDR = 0;
    localparam int DEPTH     = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        cls;
    logic [4:0]        rd, rs1, rs2;
    logic [2:0]        func3;
    logic              alt;
    logic [31:0]       imm;
    logic              finish;
    logic              start;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              err;
    logic [1:0]        err_code;
    logic [ADDR_W:0]   count;
    logic              done;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .cls(cls), .rd(rd), .rs1(rs1), .rs2(rs2), .func3(func3), .alt(alt), .imm(imm),
        .finish(finish), .start(start), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .err(err), .err_code(err_code), .count(count), .done(done)
    );

    typedef struct {
        logic [2:0]  cls;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic        alt;
        logic [31:0] imm;
        logic        ok;
        logic [1:0]  code;
        logic [31:0] word;
    } vec_t;

    int vectors    = 0;
    int miscompares = 0;
    int exp_count  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] c, input logic [4:0] d, input logic [4:0] s1,
                                input logic [4:0] s2, input logic [2:0] f, input logic a,
                                input logic [31:0] im, input logic ok, input logic [1:0] code,
                                input logic [31:0] w);
        vec_t v;
        v.cls = c; v.rd = d; v.rs1 = s1; v.rs2 = s2; v.f3 = f; v.alt = a; v.imm = im;
        v.ok = ok; v.code = code; v.word = w;
        return v;
    endfunction

    function automatic int unsigned fld(input logic [31:0] u, input int hi, input int lo);
        return (u >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
    endfunction

    // Reference: legality from numeric ranges, word assembled by shifting fields into place.
    function automatic void model(inout vec_t v);
        int signed   s;
        int unsigned u, op, f3e, d, s1, s2, w;
        bit f3_ok, imm_ok;
        s = v.imm; u = v.imm; d = v.rd; s1 = v.rs1; s2 = v.rs2;
        case (v.cls)
            3'd0: op = 32'h03;
            3'd1: op = 32'h23;
            3'd2: op = 32'h33;
            3'd3: op = 32'h63;
            3'd4: op = 32'h13;
            3'd5: op = 32'h67;
            3'd6: op = 32'h6F;
            default: op = 32'h37;
        endcase
        f3e = v.f3;
        if (v.cls == 3'd0 || v.cls == 3'd1) f3e = 2;
        if (v.cls == 3'd5) f3e = 0;
        f3_ok = 1;
        if (v.cls == 3'd2 || v.cls == 3'd4) f3_ok = v.f3 inside {3'd0, 3'd2, 3'd4, 3'd6, 3'd7};
        if (v.cls == 3'd3) f3_ok = v.f3 inside {3'd0, 3'd1, 3'd4, 3'd5};
        if (v.alt && !(v.cls == 3'd2 && v.f3 == 3'd0)) f3_ok = 0;
        case (v.cls)
            3'd2:    imm_ok = 1;
            3'd3:    imm_ok = (s >= -4096) && (s <= 4094) && (s % 2 == 0);
            3'd6:    imm_ok = (s >= -1048576) && (s <= 1048574) && (s % 2 == 0);
            3'd7:    imm_ok = (u % 4096) == 0;
            default: imm_ok = (s >= -2048) && (s <= 2047);
        endcase
        v.code = !f3_ok ? 2'd1 : (!imm_ok ? 2'd2 : 2'd0);
        v.ok   = f3_ok && imm_ok;
        case (v.cls)
            3'd1: w = (fld(u,11,5) << 25) | (s2 << 20) | (s1 << 15) | (f3e << 12) | (fld(u,4,0) << 7) | op;
            3'd2: w = ((v.alt ? 32'd32 : 32'd0) << 25) | (s2 << 20) | (s1 << 15) | (f3e << 12) | (d << 7) | op;
            3'd3: w = (fld(u,12,12) << 31) | (fld(u,10,5) << 25) | (s2 << 20) | (s1 << 15) | (f3e << 12)
                      | (fld(u,4,1) << 8) | (fld(u,11,11) << 7) | op;
            3'd6: w = (fld(u,20,20) << 31) | (fld(u,10,1) << 21) | (fld(u,11,11) << 20)
                      | (fld(u,19,12) << 12) | (d << 7) | op;
            3'd7: w = (fld(u,31,12) << 12) | (d << 7) | op;
            default: w = (fld(u,11,0) << 20) | (s1 << 15) | (f3e << 12) | (d << 7) | op;
        endcase
        v.word = w;
    endfunction

    // Called at a negedge; returns at a negedge with the bundle fully retired.
    task automatic send(input vec_t v);
        in_valid = 1'b1; cls = v.cls; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
        func3 = v.f3; alt = v.alt; imm = v.imm;
        #1;
        chk("in_ready", in_ready, exp_count < DEPTH - 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        if (exp_count == DEPTH - 1) begin
            chk("full_err", err, 1);
            chk("full_code", err_code, 3);
            chk("full_we", mem_we, 0);
        end else if (v.ok) begin
            chk("we", mem_we, 1);
            chk("addr", mem_addr, BASE_ADDR + exp_count);
            chk("wdata", mem_wdata, v.word);
            chk("no_err", err, 0);
            exp_count++;
        end else begin
            chk("err", err, 1);
            chk("err_code", err_code, v.code);
            chk("rej_we", mem_we, 0);
        end
        @(negedge clk);
        chk("we_low", mem_we, 0);
        chk("count", count, exp_count);
        chk("err_low", err, 0);
    endtask

    task automatic term_restart();
        finish = 1'b1;
        #1;
        chk("ready_fin", in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        finish = 1'b0;
        chk("term_we", mem_we, 1);
        chk("term_addr", mem_addr, BASE_ADDR + exp_count);
        chk("term_data", mem_wdata, 0);
        @(negedge clk);
        chk("done", done, 1);
        chk("done_we", mem_we, 0);
        chk("done_ready", in_ready, 0);
        chk("done_count", count, exp_count);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        exp_count = 0;
        chk("restart_done", done, 0);
        chk("restart_addr", mem_addr, BASE_ADDR);
        chk("restart_count", count, 0);
        chk("restart_ready", in_ready, 1);
    endtask

    vec_t tbl[16];
    vec_t rv;

    initial begin
        tbl[0]  = mk(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'h0,        1, 0, 32'h402081B3);
        tbl[1]  = mk(3'd4, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFFFFFF, 1, 0, 32'hFFF00293);
        tbl[2]  = mk(3'd0, 5'd6, 5'd5, 5'd0, 3'd0, 1'b0, 32'd8,        1, 0, 32'h0082A303);
        tbl[3]  = mk(3'd3, 5'd0, 5'd1, 5'd2, 3'd1, 1'b0, 32'hFFFFFFFC, 1, 0, 32'hFE209EE3);
        tbl[4]  = mk(3'd6, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048,     1, 0, 32'h001000EF);
        tbl[5]  = mk(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd3,        0, 2, 32'h0);
        tbl[6]  = mk(3'd7, 5'd4, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345001, 0, 2, 32'h0);
        tbl[7]  = mk(3'd4, 5'd5, 5'd1, 5'd0, 3'd0, 1'b1, 32'h0,        0, 1, 32'h0);
        tbl[8]  = mk(3'd1, 5'd0, 5'd2, 5'd3, 3'd0, 1'b0, 32'hFFFFF800, 1, 0, 32'h80312023);
        tbl[9]  = mk(3'd4, 5'd1, 5'd1, 5'd0, 3'd1, 1'b0, 32'h0,        0, 1, 32'h0);
        tbl[10] = mk(3'd5, 5'd1, 5'd1, 5'd0, 3'd0, 1'b0, 32'd2048,     0, 2, 32'h0);
        tbl[11] = mk(3'd7, 5'd7, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345000, 1, 0, 32'h123453B7);
        tbl[12] = mk(3'd2, 5'd1, 5'd1, 5'd1, 3'd7, 1'b1, 32'h0,        0, 1, 32'h0);
        tbl[13] = mk(3'd3, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 32'd8,        0, 1, 32'h0);
        tbl[14] = mk(3'd6, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd3,        0, 2, 32'h0);
        tbl[15] = mk(3'd5, 5'd1, 5'd2, 5'd0, 3'd7, 1'b0, 32'hFFFFFFFC, 1, 0, 32'hFFC100E7);

        rst_n = 1'b0; in_valid = 1'b0; cls = '0; rd = '0; rs1 = '0; rs2 = '0;
        func3 = '0; alt = 1'b0; imm = '0; finish = 1'b0; start = 1'b0;
        #1;
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, BASE_ADDR);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_err", err, 0);
        chk("rst_code", err_code, 0);
        chk("rst_count", count, 0);
        chk("rst_done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", in_ready, 1);

        // Directed table
        for (int i = 0; i < 16; i++) begin
            if (exp_count == DEPTH - 1) term_restart();
            send(tbl[i]);
        end

        // Memory full: fill, one extra bundle rejected with code 3, then terminate
        while (exp_count < DEPTH - 1) send(tbl[1]);
        send(tbl[0]);
        term_restart();

        // Reset while a write is on the bus
        send(tbl[5]);
        send(tbl[0]);
        in_valid = 1'b1; cls = tbl[1].cls; rd = tbl[1].rd; rs1 = tbl[1].rs1; rs2 = tbl[1].rs2;
        func3 = tbl[1].f3; alt = tbl[1].alt; imm = tbl[1].imm;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        chk("mid_we", mem_we, 1);
        rst_n = 1'b0;
        #1;
        exp_count = 0;
        chk("arst_we", mem_we, 0);
        chk("arst_addr", mem_addr, BASE_ADDR);
        chk("arst_wdata", mem_wdata, 0);
        chk("arst_err", err, 0);
        chk("arst_code", err_code, 0);
        chk("arst_count", count, 0);
        chk("arst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abandon_we", mem_we, 0);
        chk("abandon_count", count, 0);
        chk("abandon_addr", mem_addr, BASE_ADDR);

        // finish and in_valid together: only the terminator is written
        send(tbl[2]);
        in_valid = 1'b1; cls = tbl[11].cls; rd = tbl[11].rd; imm = tbl[11].imm;
        alt = 1'b0; finish = 1'b1;
        #1;
        chk("fin_valid_ready", in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; finish = 1'b0;
        chk("fin_we", mem_we, 1);
        chk("fin_addr", mem_addr, BASE_ADDR + 1);
        chk("fin_data", mem_wdata, 0);
        @(negedge clk);
        chk("fin_done", done, 1);
        chk("fin_count", count, 1);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        exp_count = 0;
        chk("fin_restart_addr", mem_addr, BASE_ADDR);

        // Randomized bundles against the reference model
        for (int n = 0; n < 300; n++) begin
            if (exp_count == DEPTH - 1) begin
                if ($urandom_range(1) == 1) send(tbl[3]);
                term_restart();
            end
            rv.cls = 3'($urandom_range(7));
            rv.rd  = 5'($urandom_range(31));
            rv.rs1 = 5'($urandom_range(31));
            rv.rs2 = 5'($urandom_range(31));
            rv.f3  = 3'($urandom_range(7));
            rv.alt = ($urandom_range(5) == 0);
            case ($urandom_range(3))
                0: rv.imm = 32'($urandom_range(4095)) - 32'd2048;
                1: rv.imm = (32'($urandom_range(2097151)) - 32'd1048576) & ~32'd1;
                2: rv.imm = $urandom;
                default: rv.imm = $urandom & 32'hFFFFF000;
            endcase
            model(rv);
            send(rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
